uart_rx_buffered: RTL and testbench

Serial UART receiver, 8N1, the receiving end of the link driven by `uart_top`'s `ser_tx`. Oversamples the line at a fixed `clocks_per_bit`, reconstructs bytes with mid-bit sampling, checks the stop bit, and queues good bytes in a small FIFO. Bytes leave through a valid/ready stream port for downstream consumers such as a console sink or a command parser.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart_rx_buffered.sv | 152 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with a registered head word.
// A push into a full FIFO is accepted only when a pop retires the head in the
// same cycle; otherwise it is dropped and flagged on o_drop.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             w_push_ok, w_pop_ok;
  logic [AW:0]      w_wptr_nxt, w_rptr_nxt;

  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok   = i_pop && !o_empty;
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_drop     = i_push && !w_push_ok;
  assign w_wptr_nxt = w_push_ok ? r_wptr + (AW+1)'(1) : r_wptr;
  assign w_rptr_nxt = w_pop_ok  ? r_rptr + (AW+1)'(1) : r_rptr;
  assign o_rdata    = r_rdata;

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  // Head register: preload the next head, bypassing a write that lands on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_wptr_nxt != w_rptr_nxt) begin
      if (w_push_ok && (r_wptr[AW-1:0] == w_rptr_nxt[AW-1:0]))
        r_rdata <= i_wdata;
      else
        r_rdata <= r_mem[w_rptr_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, stop check and a
// receive FIFO exposed as a valid/ready byte stream.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 3,
  parameter int fifo_depth     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [TW-1:0] HALF_BIT = TW'(clocks_per_bit / 2);
  localparam logic [TW-1:0] FULL_BIT = TW'(clocks_per_bit - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e r_state, w_state_nxt;

  logic                      r_sync1, r_rx_s, r_rx_prev;
  logic [TW-1:0]             r_timer;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err, r_overflow;

  logic w_fall, w_expire;
  logic w_load_half, w_load_full, w_clr_idx, w_shift, w_push, w_ferr;
  logic w_full, w_empty, w_drop;

  assign w_fall   = (r_rx_prev == UART_IDLE_LEVEL) && (r_rx_s != UART_IDLE_LEVEL);
  assign w_expire = (r_timer == '0);

  // Two-flop synchronizer plus the previous synchronized level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= UART_IDLE_LEVEL;
      r_rx_s    <= UART_IDLE_LEVEL;
      r_rx_prev <= UART_IDLE_LEVEL;
    end else begin
      r_sync1   <= ser_rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:      if (w_fall) w_state_nxt = RX_START;
      RX_START:     if (w_expire) w_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (w_expire && (r_bit_idx == LAST_BIT)) w_state_nxt = RX_STOP;
      // Line held low after a bad stop must return high before re-arming.
      RX_STOP:      if (w_expire) w_state_nxt = r_rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (r_rx_s == UART_IDLE_LEVEL) w_state_nxt = RX_IDLE;
      default:      w_state_nxt = RX_IDLE;
    endcase
  end

  // FSM output strobes driving the timer, shifter and FIFO.
  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_clr_idx   = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      RX_IDLE:  w_load_half = w_fall;
      RX_START: if (w_expire && !r_rx_s) begin
                  w_load_full = 1'b1;
                  w_clr_idx   = 1'b1;
                end
      RX_DATA:  if (w_expire) begin
                  w_shift     = 1'b1;
                  w_load_full = 1'b1;
                end
      RX_STOP:  if (w_expire) begin
                  w_push = r_rx_s;
                  w_ferr = !r_rx_s;
                end
      default:  ;
    endcase
  end

  // Bit timer: reload on strobe, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_timer <= '0;
    else if (w_load_half)  r_timer <= HALF_BIT;
    else if (w_load_full)  r_timer <= FULL_BIT;
    else if (!w_expire)    r_timer <= r_timer - TW'(1);
  end

  // Data shifter (LSB first) and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else if (w_clr_idx) begin
      r_bit_idx <= '0;
    end else if (w_shift) begin
      r_shift   <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Frame error pulse and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overflow  <= r_overflow | w_drop;
    end
  end

  uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (out_ready),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign out_valid = !w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: one instance at 8 clocks/bit for the
// timing-sensitive scenarios, one at 3 clocks/bit for a back-to-back stream.
module tb_uart_rx_buffered;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser8, rdy8, ov8, fe8, of8;
  logic [7:0] od8;
  logic       ser3, rdy3, ov3, fe3, of3;
  logic [7:0] od3;

  int checks = 0;
  int errors = 0;
  int ferr8_cnt = 0;
  int ferr3_cnt = 0;
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  uart_rx_buffered #(.clocks_per_bit(8), .fifo_depth(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ser_rx(ser8), .out_data(od8), .out_valid(ov8),
    .out_ready(rdy8), .frame_err(fe8), .overflow(of8));

  uart_rx_buffered #(.clocks_per_bit(3), .fifo_depth(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ser_rx(ser3), .out_data(od3), .out_valid(ov3),
    .out_ready(rdy3), .frame_err(fe3), .overflow(of3));

  // Passive monitors: frame error pulses and accepted bytes of the stream DUT.
  always @(negedge clk) begin
    if (fe8) ferr8_cnt <= ferr8_cnt + 1;
    if (fe3) ferr3_cnt <= ferr3_cnt + 1;
    if (ov3 && rdy3) q3.push_back(od3);
  end

  // Hold one serial bit for sel clocks (sel is also the clocks_per_bit value).
  task automatic drive_bit(input int sel, input logic v);
    if (sel == 3) ser3 = v; else ser8 = v;
    repeat (sel) @(negedge clk);
  endtask

  task automatic tx_frame(input int sel, input logic [7:0] b, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    drive_bit(sel, stop_bit);
  endtask

  // Bounded wait for out_valid on the 8-clock DUT; the caller checks the outcome.
  task automatic wait_valid8();
    int n = 0;
    while (!ov8 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop8();
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ser8 = 1'b1; ser3 = 1'b1; rdy8 = 1'b0; rdy3 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ov8); end
    checks++; if (od8 !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", od8); end
    checks++; if (fe8 !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", fe8); end
    checks++; if (of8 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", of8); end
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_valid3: got %b want 0", ov3); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Back-to-back frames at 3 clocks/bit with exactly one stop bit each.
  task automatic test_loopback();
    logic [7:0] msg [5];
    int c0;
    msg = '{8'h48, 8'h69, 8'h21, 8'h0A, 8'hFF};
    c0 = ferr3_cnt;
    for (int i = 0; i < 5; i++) tx_frame(3, msg[i], 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (q3.size() != 5) begin errors++; $display("FAIL loop_count: got %0d want 5", q3.size()); end
    for (int i = 0; i < 5 && i < q3.size(); i++) begin
      checks++;
      if (q3[i] !== msg[i]) begin errors++; $display("FAIL loop_byte%0d: got %02h want %02h", i, q3[i], msg[i]); end
    end
    checks++; if (ferr3_cnt != c0) begin errors++; $display("FAIL loop_ferr: got %0d pulses want 0", ferr3_cnt - c0); end
    checks++; if (of3 !== 1'b0) begin errors++; $display("FAIL loop_ovf: got %b want 0", of3); end
  endtask

  // 0xA5 at 8 clocks/bit; out_valid rises 2+4+72+1 = 79 cycles after the first
  // rising edge that sees ser_rx low.
  task automatic test_latency();
    int n = 0;
    fork
      tx_frame(8, 8'hA5, 1'b1);
      begin
        @(posedge clk);
        n = 0;
        while (n < 200) begin
          @(posedge clk); #1; n++;
          if (ov8) break;
        end
      end
    join
    @(negedge clk);
    checks++; if (n != 79) begin errors++; $display("FAIL a5_latency: got %0d cycles want 79", n); end
    checks++; if (ov8 !== 1'b1 || od8 !== 8'hA5) begin errors++; $display("FAIL a5_data: got v=%b %02h want v=1 a5", ov8, od8); end
    pop8();
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL a5_empty: got valid %b want 0", ov8); end
  endtask

  // One-cycle low glitch must be rejected as a false start.
  task automatic test_glitch();
    int c0 = ferr8_cnt;
    ser8 = 1'b0; @(negedge clk); ser8 = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL glitch_push: got valid %b want 0", ov8); end
    checks++; if (ferr8_cnt != c0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr8_cnt - c0); end
    tx_frame(8, 8'h5A, 1'b1);
    wait_valid8();
    checks++; if (ov8 !== 1'b1 || od8 !== 8'h5A) begin errors++; $display("FAIL glitch_next: got v=%b %02h want v=1 5a", ov8, od8); end
    if (ov8) pop8();
  endtask

  // Stop bit low followed by a 30-bit break: one pulse, no push, then recovery.
  task automatic test_bad_stop();
    int c0 = ferr8_cnt;
    tx_frame(8, 8'h3C, 1'b0);
    ser8 = 1'b0;
    repeat (30 * 8) @(negedge clk);
    checks++; if (ferr8_cnt - c0 != 1) begin errors++; $display("FAIL badstop_ferr: got %0d pulses want 1", ferr8_cnt - c0); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL badstop_push: got valid %b want 0", ov8); end
    ser8 = 1'b1;
    repeat (16) @(negedge clk);
    tx_frame(8, 8'h42, 1'b1);
    wait_valid8();
    checks++; if (ov8 !== 1'b1 || od8 !== 8'h42) begin errors++; $display("FAIL badstop_next: got v=%b %02h want v=1 42", ov8, od8); end
    if (ov8) pop8();
    checks++; if (ferr8_cnt - c0 != 1) begin errors++; $display("FAIL badstop_total: got %0d pulses want 1", ferr8_cnt - c0); end
  endtask

  // Full FIFO with a pop on the exact stop-sample cycle of 0x77 (edge 80).
  task automatic test_full_pop();
    logic [7:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'h77};
    tx_frame(8, 8'h11, 1'b1);
    tx_frame(8, 8'h22, 1'b1);
    tx_frame(8, 8'h33, 1'b1);
    tx_frame(8, 8'h44, 1'b1);
    checks++; if (ov8 !== 1'b1 || od8 !== 8'h11) begin errors++; $display("FAIL fullpop_head: got v=%b %02h want v=1 11", ov8, od8); end
    fork
      tx_frame(8, 8'h77, 1'b1);
      begin
        repeat (79) @(negedge clk);
        rdy8 = 1'b1;
        @(negedge clk);
        rdy8 = 1'b0;
      end
    join
    checks++; if (of8 !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", of8); end
    for (int i = 0; i < 4; i++) begin
      wait_valid8();
      checks++;
      if (ov8 !== 1'b1 || od8 !== exp[i]) begin errors++; $display("FAIL fullpop_drain%0d: got v=%b %02h want v=1 %02h", i, ov8, od8, exp[i]); end
      if (ov8) pop8();
    end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got valid %b want 0", ov8); end
  endtask

  // Five bytes into a 4-deep FIFO with no consumer.
  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) tx_frame(8, 8'(i), 1'b1);
    checks++; if (of8 !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", of8); end
    tx_frame(8, 8'h05, 1'b1);
    checks++; if (of8 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", of8); end
    for (int i = 1; i <= 4; i++) begin
      wait_valid8();
      checks++;
      if (ov8 !== 1'b1 || od8 !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: got v=%b %02h want v=1 %02h", i, ov8, od8, 8'(i)); end
      if (ov8) pop8();
    end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL ovf_empty: got valid %b want 0", ov8); end
    checks++; if (of8 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", of8); end
  endtask

  // Reset in the middle of a frame discards the FIFO and the partial byte.
  task automatic test_reset_midframe();
    int c0;
    tx_frame(8, 8'h99, 1'b1);
    drive_bit(8, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8, 1'b0);
    ser8 = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", ov8); end
    checks++; if (od8 !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %02h want 00", od8); end
    checks++; if (of8 !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", of8); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = ferr8_cnt;
    repeat (40) @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got valid %b want 0", ov8); end
    tx_frame(8, 8'hC3, 1'b1);
    wait_valid8();
    checks++; if (ov8 !== 1'b1 || od8 !== 8'hC3) begin errors++; $display("FAIL rstmid_next: got v=%b %02h want v=1 c3", ov8, od8); end
    if (ov8) pop8();
    checks++; if (ferr8_cnt != c0) begin errors++; $display("FAIL rstmid_ferr: got %0d pulses want 0", ferr8_cnt - c0); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_latency();
    test_glitch();
    test_bad_stop();
    test_full_pop();
    test_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
